// File: rtl/chan_mux_pkg.sv
// Shared constants for the chan_mux_rr channel multiplexer.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int              CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/chan_mux_rr_if.sv
// Handshake bundle for chan_mux_rr: N_CH producer channels in, one consumer out.
interface chan_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SELW = $clog2(N_CH);

  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SELW-1:0]       out_ch;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/chan_mux_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr, wrapping modulo N_CH.
module rr_pick #(
  parameter  int N_CH = 4,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // k = N_CH lands back on ptr itself, so it has the lowest priority
    for (int k = 1; k <= N_CH; k++) begin
      if (!gnt_vld && req[(int'(ptr) + k) % N_CH]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'((int'(ptr) + k) % N_CH);
      end
    end
  end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered mux with fixed-select or round-robin arbitration.
// Optional per-channel grant counters behind CHMUX_STATS_EN.
module chan_mux_rr
  import chan_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CHMUX_STATS_EN
  input  logic [SELW-1:0]  stat_sel,
  output logic [CNT_W-1:0] stat_cnt,
`endif
  chan_mux_rr_if.slave     bus
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load;
  logic             rr_vld, fx_vld, gnt_vld, xfer;
  logic [SELW-1:0]  rr_idx, fx_idx, gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [N_CH-1:0]  in_ready_c;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  always_comb begin
    load = !out_valid_q || bus.out_ready;

    // sel values >= N_CH never match a channel, so they grant nothing
    fx_vld = 1'b0;
    fx_idx = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (bus.sel == SELW'(c) && bus.in_valid[c]) begin
        fx_vld = 1'b1;
        fx_idx = SELW'(c);
      end
    end

    gnt_vld = (bus.mode == MODE_RR) ? rr_vld : fx_vld;
    gnt_idx = (bus.mode == MODE_RR) ? rr_idx : fx_idx;
    xfer    = gnt_vld && load;

    gnt_data   = '0;
    in_ready_c = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (gnt_idx == SELW'(c)) begin
        gnt_data      = bus.in_data[c*WIDTH +: WIDTH];
        in_ready_c[c] = gnt_vld && load;
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
      if (bus.mode == MODE_RR) ptr_d = gnt_idx;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SELW'(N_CH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;

`ifdef CHMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    stat_cnt_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (xfer && gnt_idx == SELW'(c) && cnt_q[c] != CNT_MAX)
        cnt_d[c] = cnt_q[c] + 1'b1;
      if (stat_sel == SELW'(c))
        stat_cnt_d = cnt_q[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= '0;
      stat_cnt_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule
